// File: rtl/exp_cordic_sequencer.sv
`timescale 1ns/1ps
// exp_cordic_sequencer
//   Front-end sequencer for the exponential CORDIC core. It takes one argument
//   at a time, launches the core with a single-cycle CORE_BEGIN pulse and waits
//   for CORE_ACK. It then hands the captured result and the accumulated
//   overflow/underflow flags downstream. A watchdog aborts a hung core: the core
//   is reset for two cycles and a zero result is returned with OUT_TIMEOUT set.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   IN_VALID/IN_READY   argument handshake, IN_T is the argument
//   CORE_T              argument to the core, held from START until the next accept
//   CORE_BEGIN          one-cycle start pulse to the core
//   CORE_RST            core reset request (during RST and watchdog recovery)
//   CORE_ACK            core done level, CORE_RESULT / CORE_FLAGS from the core
//   OUT_VALID/OUT_READY result handshake
//   OUT_RESULT          captured result (0 after a timeout)
//   OUT_FLAGS           {U_FZ,U_FY,U_FX,O_FZ,O_FY,O_FX}, OR of every WAIT cycle
//   OUT_TIMEOUT         result was produced by the watchdog
//   BUSY                sequencer is not idle
module exp_cordic_sequencer #(
  parameter int P       = 32,
  parameter int TIMEOUT = 200,
  parameter int TMR_W   = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [P-1:0] IN_T,
  output logic [P-1:0] CORE_T,
  output logic         CORE_BEGIN,
  output logic         CORE_RST,
  input  logic         CORE_ACK,
  input  logic [P-1:0] CORE_RESULT,
  input  logic [5:0]   CORE_FLAGS,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [P-1:0] OUT_RESULT,
  output logic [5:0]   OUT_FLAGS,
  output logic         OUT_TIMEOUT,
  output logic         BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RECOVER,
    S_HOLD
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [P-1:0]     core_t_q, core_t_d;
  logic             core_begin_q, core_begin_d;
  logic             core_rst_q, core_rst_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [5:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic [P-1:0]     out_result_q, out_result_d;
  logic [5:0]       out_flags_q, out_flags_d;
  logic             out_timeout_q, out_timeout_d;
  logic             busy_q, busy_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      core_t_q      <= '0;
      core_begin_q  <= 1'b0;
      core_rst_q    <= 1'b1;
      timer_q       <= '0;
      flags_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      core_t_q      <= core_t_d;
      core_begin_q  <= core_begin_d;
      core_rst_q    <= core_rst_d;
      timer_q       <= timer_d;
      flags_q       <= flags_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      out_timeout_q <= out_timeout_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    core_t_d      = core_t_q;
    core_begin_d  = 1'b0;
    core_rst_d    = 1'b0;
    timer_d       = timer_q;
    flags_d       = flags_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    out_timeout_d = out_timeout_q;

    case (state_q)
      S_IDLE: begin
        // IN_READY comes up one cycle after entering IDLE.
        in_ready_d = 1'b1;
        if (IN_VALID && in_ready_q) begin
          in_ready_d   = 1'b0;
          core_t_d     = IN_T;
          flags_d      = '0;
          timer_d      = '0;
          core_begin_d = 1'b1;
          state_d      = S_START;
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_q + TMR_ONE;
        flags_d = flags_q | CORE_FLAGS;
        // An ACK seen while timer is still 0 may be left over from the previous
        // operation, so only ACKs from the second WAIT cycle on are trusted.
        // The ACK test comes first so it beats a simultaneous timeout.
        if (CORE_ACK && (timer_q != '0)) begin
          out_result_d  = CORE_RESULT;
          out_flags_d   = flags_q | CORE_FLAGS;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = S_HOLD;
        end else if (timer_q == TMR_LAST) begin
          out_result_d  = '0;
          out_flags_d   = flags_q | CORE_FLAGS;
          out_timeout_d = 1'b1;
          core_rst_d    = 1'b1;
          timer_d       = '0;
          state_d       = S_RECOVER;
        end
      end

      S_RECOVER: begin
        // CORE_RST was raised on entry; keep it for one more cycle so the core
        // sees exactly two reset cycles, then present the timeout result.
        timer_d = timer_q + TMR_ONE;
        if (timer_q == '0) begin
          core_rst_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered from the next state so BUSY lines up with the state register.
    busy_d = (state_d != S_IDLE);
  end

  assign IN_READY    = in_ready_q;
  assign CORE_T      = core_t_q;
  assign CORE_BEGIN  = core_begin_q;
  assign CORE_RST    = core_rst_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_RESULT  = out_result_q;
  assign OUT_FLAGS   = out_flags_q;
  assign OUT_TIMEOUT = out_timeout_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_exp_cordic_sequencer.sv
`timescale 1ns/1ps
// Testbench for exp_cordic_sequencer: directed arguments, a behavioural core
// model, and a scoreboard queue checked by an independent output monitor.
module tb_exp_cordic_sequencer;

  localparam int P       = 32;
  localparam int TIMEOUT = 200;
  localparam int TMR_W   = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [P-1:0] IN_T;
  logic [P-1:0] CORE_T;
  logic         CORE_BEGIN;
  logic         CORE_RST;
  logic         CORE_ACK;
  logic [P-1:0] CORE_RESULT;
  logic [5:0]   CORE_FLAGS;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [P-1:0] OUT_RESULT;
  logic [5:0]   OUT_FLAGS;
  logic         OUT_TIMEOUT;
  logic         BUSY;

  exp_cordic_sequencer #(
    .P       (P),
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_T        (IN_T),
    .CORE_T      (CORE_T),
    .CORE_BEGIN  (CORE_BEGIN),
    .CORE_RST    (CORE_RST),
    .CORE_ACK    (CORE_ACK),
    .CORE_RESULT (CORE_RESULT),
    .CORE_FLAGS  (CORE_FLAGS),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_RESULT  (OUT_RESULT),
    .OUT_FLAGS   (OUT_FLAGS),
    .OUT_TIMEOUT (OUT_TIMEOUT),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] result;
    logic [5:0]  flags;
    logic        timeout;
  } exp_t;
  exp_t sb_q[$];

  // core model configuration, set before each argument is sent
  int          cfg_ack;
  int          cfg_pulse;
  logic [5:0]  cfg_pulse_flags;
  logic [5:0]  cfg_ack_flags;
  logic [31:0] cfg_result;
  bit          cfg_hold_ack;

  int ack_stamp   = 0;
  int begin_stamp = 0;
  int xfer_no     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_core(input int ack, input logic [31:0] res, input int pulse,
                          input logic [5:0] pflags, input logic [5:0] aflags, input bit hold);
    cfg_ack         = ack;
    cfg_result      = res;
    cfg_pulse       = pulse;
    cfg_pulse_flags = pflags;
    cfg_ack_flags   = aflags;
    cfg_hold_ack    = hold;
  endtask

  // Core model: WAIT cycle c is the c-th cycle after the START cycle, so the
  // DUT timer equals c during it. An ACK left high from the previous operation
  // is only dropped in WAIT cycle 1.
  initial begin
    CORE_ACK    = 1'b0;
    CORE_RESULT = '0;
    CORE_FLAGS  = '0;
    forever begin
      @(negedge CLK);
      if (CORE_BEGIN && !RST) begin
        for (int c = 0; c < TIMEOUT + 20; c++) begin
          @(posedge CLK);
          #1;
          if (RST || CORE_RST) begin
            CORE_ACK   = 1'b0;
            CORE_FLAGS = '0;
            break;
          end
          CORE_FLAGS = '0;
          if (c >= 1) CORE_ACK = 1'b0;
          if (c == cfg_pulse) CORE_FLAGS = cfg_pulse_flags;
          if (c == cfg_ack) begin
            CORE_ACK    = 1'b1;
            CORE_RESULT = cfg_result;
            CORE_FLAGS  = cfg_ack_flags;
            ack_stamp   = cyc;
            @(posedge CLK);
            #1;
            CORE_FLAGS = '0;
            if (!cfg_hold_ack) CORE_ACK = 1'b0;
            break;
          end
        end
      end
    end
  end

  // Monitor: BEGIN width, OUT_VALID timing, and scoreboard comparison on transfer.
  bit prev_valid = 1'b0;
  bit prev_begin = 1'b0;
  int begin_len  = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (CORE_BEGIN) begin
        begin_len++;
        begin_stamp = cyc;
      end else begin
        if (prev_begin) check("begin_width", 64'(begin_len), 64'(1));
        begin_len = 0;
      end
      if (OUT_VALID && !prev_valid) begin
        if (sb_q.size() == 0)
          check("unexpected_valid", 64'(OUT_VALID), 64'(0));
        else if (sb_q[0].timeout)
          check("valid_latency_timeout", 64'(cyc), 64'(begin_stamp + TIMEOUT + 3));
        else
          check("valid_latency", 64'(cyc), 64'(ack_stamp + 1));
      end
      if (OUT_VALID && OUT_READY && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        xfer_no++;
        $display("[TB] xfer %0d: result=%h flags=%b timeout=%0d (expected %h %b %0d)",
                 xfer_no, OUT_RESULT, OUT_FLAGS, OUT_TIMEOUT, e.result, e.flags, e.timeout);
        check("out_result", 64'(OUT_RESULT), 64'(e.result));
        check("out_flags", 64'(OUT_FLAGS), 64'(e.flags));
        check("out_timeout", 64'(OUT_TIMEOUT), 64'(e.timeout));
      end
      prev_valid = OUT_VALID;
      prev_begin = CORE_BEGIN;
    end
  end

  task automatic send(input logic [31:0] t, input bit expect_out, input logic [31:0] er,
                      input logic [5:0] ef, input logic et);
    int n;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b1;
    IN_T     = t;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!IN_READY && n < 400);
    check("in_ready_wait", 64'(IN_READY), 64'(1));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    if (expect_out) sb_q.push_back('{result: er, flags: ef, timeout: et});
    @(negedge CLK);
    check("core_t", 64'(CORE_T), 64'(t));
    check("busy", 64'(BUSY), 64'(1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !IN_READY) && n < 600) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int          n;
    bit          stable;
    bit          seen;
    logic [31:0] snap_r;
    logic [5:0]  snap_f;
    logic        snap_t;

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_T      = '0;
    OUT_READY = 1'b1;
    set_core(-1, 32'h0, -1, 6'b0, 6'b0, 1'b0);

    // reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", 64'(IN_READY), 64'(0));
    check("rst_core_rst", 64'(CORE_RST), 64'(1));
    check("rst_core_begin", 64'(CORE_BEGIN), 64'(0));
    check("rst_out_valid", 64'(OUT_VALID), 64'(0));
    check("rst_out_timeout", 64'(OUT_TIMEOUT), 64'(0));
    check("rst_core_t", 64'(CORE_T), 64'(0));
    check("rst_out_result", 64'(OUT_RESULT), 64'(0));
    check("rst_out_flags", 64'(OUT_FLAGS), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("release_in_ready", 64'(IN_READY), 64'(1));
    check("release_core_rst", 64'(CORE_RST), 64'(0));

    // normal operation, ACK at WAIT cycle 40 and left high afterwards
    set_core(40, 32'h402DF854, -1, 6'b0, 6'b0, 1'b1);
    send(32'h3F800000, 1'b1, 32'h402DF854, 6'b000000, 1'b0);
    wait_done();

    // stale ACK from the previous op plus backpressure
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    set_core(5, 32'h3FD3094C, -1, 6'b0, 6'b0, 1'b0);
    send(32'h3F000000, 1'b1, 32'h3FD3094C, 6'b000000, 1'b0);
    n = 0;
    while (!OUT_VALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("bp_valid_seen", 64'(OUT_VALID), 64'(1));
    snap_r = OUT_RESULT;
    snap_f = OUT_FLAGS;
    snap_t = OUT_TIMEOUT;
    stable = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (!OUT_VALID || IN_READY || OUT_RESULT !== snap_r || OUT_FLAGS !== snap_f ||
          OUT_TIMEOUT !== snap_t)
        stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'(1));
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    wait_done();

    // sticky flags: O_FY pulse mid-WAIT, U_FZ on the ACK cycle
    set_core(30, 32'h3FA45AFC, 20, 6'b000010, 6'b100000, 1'b0);
    send(32'h3E800000, 1'b1, 32'h3FA45AFC, 6'b100010, 1'b0);
    wait_done();

    // watchdog: no ACK, O_FX pulse kept in the timeout result
    set_core(-1, 32'h0, 50, 6'b000001, 6'b0, 1'b0);
    send(32'h42C80000, 1'b1, 32'h00000000, 6'b000001, 1'b1);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CORE_RST && n < 300);
    check("wd_core_rst_cycle", 64'(cyc), 64'(begin_stamp + TIMEOUT + 1));
    n = 0;
    while (CORE_RST && n < 10) begin
      n++;
      @(negedge CLK);
    end
    check("wd_core_rst_len", 64'(n), 64'(2));
    wait_done();

    // ACK on the last WAIT cycle beats the timeout
    set_core(TIMEOUT - 1, 32'h40EC7326, -1, 6'b0, 6'b0, 1'b0);
    send(32'h40000000, 1'b1, 32'h40EC7326, 6'b000000, 1'b0);
    wait_done();

    // reset during WAIT discards the operation
    set_core(-1, 32'h0, -1, 6'b0, 6'b0, 1'b0);
    send(32'h3F800000, 1'b0, 32'h0, 6'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_core_rst", 64'(CORE_RST), 64'(1));
    check("midrst_busy", 64'(BUSY), 64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    seen = 1'b0;
    repeat (250) begin
      @(negedge CLK);
      if (OUT_VALID) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'(0));
    set_core(3, 32'h3EBC5AB2, -1, 6'b0, 6'b0, 1'b0);
    send(32'hBF800000, 1'b1, 32'h3EBC5AB2, 6'b000000, 1'b0);
    wait_done();

    repeat (5) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
